fft_frame_feeder: RTL

- Upstream stage of the even/odd split interconnect that feeds the half-size sFFT.
- Buffers the incoming I/Q sample stream in a FIFO and emits exactly NFFT samples per frame, each tagged with its in-frame index on o_counter_data.
- After a frame, it holds the stream until the interconnect's active-low "odd half drained" pulse arrives, then releases the next frame.
- Samples arriving while the interconnect drains its odd buffer are therefore not lost.

---
 rtl/fft_frame_feeder.sv | 99 +++++++++
 1 files changed

// File: rtl/fft_frame_feeder.sv
// Buffers the I/Q stream and emits NFFT-sample indexed frames, pausing between frames until the done pulse.
// Latency: 2 cycles from sample strobe to output strobe; no upstream backpressure, full FIFO drops and flags overflow.
module fft_frame_feeder #(
  parameter int SIZE_BUFFER     = 1,
  parameter int DATA_FFT_SIZE   = 16,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [DATA_FFT_SIZE-1:0]   i_in_data_i,
  input  logic [DATA_FFT_SIZE-1:0]   i_in_data_q,
  input  logic                       i_valid,
  input  logic                       i_wayt_data_second_NChet,
  output logic [DATA_FFT_SIZE-1:0]   o_out_data_i,
  output logic [DATA_FFT_SIZE-1:0]   o_out_data_q,
  output logic                       o_outvalid,
  output logic [SIZE_BUFFER:0]       o_counter_data,
  output logic [FIFO_DEPTH_LOG2:0]   o_fifo_level,
  output logic                       o_overflow,
  output logic                       o_proto_err,
  output logic                       o_frame_busy
);

  localparam int DEPTH_INT = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH = DEPTH_INT[FIFO_DEPTH_LOG2:0];
  localparam logic [SIZE_BUFFER-1:0] LAST_IDX = '1;

  typedef enum logic {
    SEND      = 1'b0,
    WAIT_DONE = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [2*DATA_FFT_SIZE-1:0] mem [DEPTH_INT];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   level;
  logic [SIZE_BUFFER-1:0]     idx;
  logic                       rd_en, wr_en, full, empty;

  assign full  = (level == DEPTH);
  assign empty = (level == '0);
  assign rd_en = (state == SEND) && !empty;
  // A read in the same cycle frees a slot, so a full FIFO can still accept.
  assign wr_en = i_valid && (!full || rd_en);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= SEND;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEND:      if (rd_en && idx == LAST_IDX) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!i_wayt_data_second_NChet) state_nxt = SEND;
      default:   state_nxt = SEND;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= {i_in_data_i, i_in_data_q};
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      idx            <= '0;
      o_out_data_i   <= '0;
      o_out_data_q   <= '0;
      o_outvalid     <= 1'b0;
      o_counter_data <= '0;
      o_overflow     <= 1'b0;
      o_proto_err    <= 1'b0;
    end else begin
      o_outvalid <= rd_en;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr                       <= rd_ptr + 1'b1;
        idx                          <= idx + 1'b1;
        {o_out_data_i, o_out_data_q} <= mem[rd_ptr];
        o_counter_data               <= {1'b0, idx};
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (i_valid && !wr_en) o_overflow <= 1'b1;
      if (state == SEND && !i_wayt_data_second_NChet) o_proto_err <= 1'b1;
    end
  end

  assign o_fifo_level = level;
  assign o_frame_busy = (state == SEND);

endmodule
